// File: rtl/branch_predict_unit.sv
// Fetch-time branch prediction (2-bit BHT + direct-mapped BTB) with execute-stage
// resolution, a registered one-cycle redirect on mispredict, and a saturating mispredict count.
module branch_predict_unit #(
    parameter int MXLEN     = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MXLEN-1:0] f_pc,
    output logic             f_pred_taken,
    output logic [MXLEN-1:0] f_pred_target,
    input  logic             ex_valid,
    input  logic [2:0]       ex_funct3,
    input  logic [1:0]       ex_cmp,
    input  logic [MXLEN-1:0] ex_pc,
    input  logic [MXLEN-1:0] ex_target,
    input  logic [MXLEN-1:0] ex_incpc,
    input  logic             ex_pred_taken,
    input  logic [MXLEN-1:0] ex_pred_target,
    output logic             redirect_valid,
    output logic [MXLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int DEPTH = 2 ** BHT_IDX_W;
    localparam int TAG_W = MXLEN - BHT_IDX_W - 2;

    logic [1:0]           bht_r        [DEPTH];
    logic [DEPTH-1:0]     btb_valid_r;
    logic [TAG_W-1:0]     btb_tag_r    [DEPTH];
    logic [MXLEN-1:0]     btb_target_r [DEPTH];

    logic                 redirect_valid_r;
    logic [MXLEN-1:0]     redirect_pc_r;
    logic [CNT_W-1:0]     mispredict_cnt_r;

    logic [BHT_IDX_W-1:0] f_idx_s;
    logic [TAG_W-1:0]     f_tag_s;
    logic [BHT_IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0]     ex_tag_s;
    logic                 is_branch_s;
    logic                 accept_s;
    logic                 taken_s;
    logic                 mispredict_s;
    logic                 unused_s;

    // GT and the reserved compare code 11 both count as "not LT and not EQ".
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [1:0] cmp);
        logic eq;
        logic lt;
        eq = (cmp == 2'b00);
        lt = (cmp == 2'b01);
        case (funct3)
            3'b000:          return eq;
            3'b001:          return !eq;
            3'b100, 3'b110:  return lt;
            3'b101, 3'b111:  return !lt;
            default:         return 1'b0;
        endcase
    endfunction

    assign f_idx_s  = f_pc[BHT_IDX_W+1:2];
    assign f_tag_s  = f_pc[MXLEN-1:BHT_IDX_W+2];
    assign ex_idx_s = ex_pc[BHT_IDX_W+1:2];
    assign ex_tag_s = ex_pc[MXLEN-1:BHT_IDX_W+2];
    assign unused_s = ^{f_pc[1:0], ex_pc[1:0]};

    // Resolution decode; anything arriving during a redirect pulse is wrong-path.
    always_comb begin
        is_branch_s  = (ex_funct3[2:1] != 2'b01);
        accept_s     = ex_valid && !redirect_valid_r && is_branch_s;
        taken_s      = branch_taken(ex_funct3, ex_cmp);
        mispredict_s = (taken_s != ex_pred_taken) ||
                       (taken_s && (ex_target != ex_pred_target));
    end

    // Fetch lookup reads current table contents (updates land at the clock edge).
    always_comb begin
        f_pred_taken  = 1'b0;
        f_pred_target = {MXLEN{1'b0}};
        if (bht_r[f_idx_s][1] && btb_valid_r[f_idx_s] && (btb_tag_r[f_idx_s] == f_tag_s)) begin
            f_pred_taken  = 1'b1;
            f_pred_target = btb_target_r[f_idx_s];
        end else begin
            f_pred_taken  = 1'b0;
            f_pred_target = {MXLEN{1'b0}};
        end
    end

    // Redirect pulse, redirect address and saturating mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {MXLEN{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            redirect_valid_r <= accept_s && mispredict_s;
            if (accept_s && mispredict_s) begin
                redirect_pc_r <= taken_s ? ex_target : ex_incpc;
                if (mispredict_cnt_r != {CNT_W{1'b1}}) begin
                    mispredict_cnt_r <= mispredict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // BHT 2-bit saturating counters, reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (accept_s) begin
            if (taken_s && (bht_r[ex_idx_s] != 2'b11)) begin
                bht_r[ex_idx_s] <= bht_r[ex_idx_s] + 2'b01;
            end else if (!taken_s && (bht_r[ex_idx_s] != 2'b00)) begin
                bht_r[ex_idx_s] <= bht_r[ex_idx_s] - 2'b01;
            end
        end
    end

    // BTB valid bits; only taken branches allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_r <= {DEPTH{1'b0}};
        end else if (accept_s && taken_s) begin
            btb_valid_r[ex_idx_s] <= 1'b1;
        end
    end

    // BTB tag/target payload; qualified by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept_s && taken_s) begin
            btb_tag_r[ex_idx_s]    <= ex_tag_s;
            btb_target_r[ex_idx_s] <= ex_target;
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign mispredict_cnt = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: expected redirects go into a scoreboard queue checked by a monitor;
// a second instance with a 2-bit mispredict counter shares the stimulus.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        ex_valid;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_cmp;
    logic [31:0] ex_pc, ex_target, ex_incpc, ex_pred_target;
    logic        ex_pred_taken;

    logic        f_pred_taken, f_pred_taken2;
    logic [31:0] f_pred_target, f_pred_target2;
    logic        redirect_valid, redirect_valid2;
    logic [31:0] redirect_pc, redirect_pc2;
    logic [15:0] mispredict_cnt;
    logic [1:0]  mispredict_cnt2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_cnt  = 0;
    logic [31:0] q_pc  [$];
    int          q_cnt [$];

    always #5 clk = ~clk;

    branch_predict_unit #(.MXLEN(32), .BHT_IDX_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
        .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
        .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_cmp(ex_cmp), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_incpc(ex_incpc), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
    );

    branch_predict_unit #(.MXLEN(32), .BHT_IDX_W(6), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
        .f_pred_taken(f_pred_taken2), .f_pred_target(f_pred_target2),
        .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_cmp(ex_cmp), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_incpc(ex_incpc), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .mispredict_cnt(mispredict_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (redirect_valid || redirect_valid2)) begin
            if (q_pc.size() == 0) begin
                check("unexpected_redirect", {31'd0, redirect_valid}, 32'd0);
            end else begin
                logic [31:0] e_pc;
                int          e_cnt;
                e_pc  = q_pc.pop_front();
                e_cnt = q_cnt.pop_front();
                check("redirect_valid2", {31'd0, redirect_valid2}, 32'd1);
                check("redirect_pc", redirect_pc, e_pc);
                check("redirect_pc2", redirect_pc2, e_pc);
                check("mispredict_cnt", {16'd0, mispredict_cnt}, e_cnt);
                check("mispredict_cnt2", {30'd0, mispredict_cnt2}, (e_cnt > 3) ? 32'd3 : e_cnt);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one resolving instruction for a cycle; queues the redirect it should cause.
    task automatic resolve(input logic [2:0] f3, input logic [1:0] cmp, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic [31:0] inc, input logic pt,
                           input logic [31:0] ptgt, input logic exp_redir, input logic [31:0] exp_pc);
        ex_funct3 = f3; ex_cmp = cmp; ex_pc = pc; ex_target = tgt; ex_incpc = inc;
        ex_pred_taken = pt; ex_pred_target = ptgt; ex_valid = 1'b1;
        if (exp_redir) begin
            exp_cnt++;
            q_pc.push_back(exp_pc);
            q_cnt.push_back(exp_cnt);
        end
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc, input logic exp_t,
                          input logic [31:0] exp_tgt);
        f_pc = pc;
        #1;
        check({name, "_taken"}, {31'd0, f_pred_taken}, {31'd0, exp_t});
        check({name, "_target"}, f_pred_target, exp_tgt);
    endtask

    initial begin
        rst_n = 1'b0; f_pc = 32'h100; ex_valid = 1'b0; ex_funct3 = 3'b000; ex_cmp = 2'b00;
        ex_pc = 32'h0; ex_target = 32'h0; ex_incpc = 32'h0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        #12 rst_n = 1'b1;
        idle(1);

        // Reset state
        lookup("reset_lookup", 32'h100, 1'b0, 32'h0);
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset_cnt", {16'd0, mispredict_cnt}, 32'd0);

        // BEQ taken, predicted not-taken; same-cycle lookup sees old contents
        f_pc = 32'h100;
        ex_funct3 = 3'b000; ex_cmp = 2'b00; ex_pc = 32'h100; ex_target = 32'h80;
        ex_incpc = 32'h104; ex_pred_taken = 1'b0; ex_pred_target = 32'h0; ex_valid = 1'b1;
        exp_cnt++; q_pc.push_back(32'h80); q_cnt.push_back(exp_cnt);
        #1 check("same_cycle_lookup", {31'd0, f_pred_taken}, 32'd0);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        lookup("beq_learned", 32'h100, 1'b1, 32'h80);
        idle(1);

        // BNE not taken but predicted taken; wrong-path instruction in the pulse cycle
        resolve(3'b001, 2'b00, 32'h104, 32'h500, 32'h108, 1'b1, 32'h500, 1'b1, 32'h108);
        check("pulse_active", {31'd0, redirect_valid}, 32'd1);
        resolve(3'b000, 2'b00, 32'h310, 32'h400, 32'h314, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1);
        check("wrongpath_cnt", {16'd0, mispredict_cnt}, 32'd2);
        lookup("wrongpath_no_update", 32'h310, 1'b0, 32'h0);
        // BHT floor at idx 1: another not-taken, then one taken leaves it weakly not-taken
        resolve(3'b001, 2'b00, 32'h104, 32'h500, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0);
        resolve(3'b001, 2'b01, 32'h104, 32'h500, 32'h108, 1'b0, 32'h0, 1'b1, 32'h500);
        idle(1);
        lookup("bht_floor", 32'h104, 1'b0, 32'h0);

        // Alias: 0x200 shares idx 0 with 0x100 but has a different tag
        resolve(3'b000, 2'b00, 32'h100, 32'h80, 32'h104, 1'b1, 32'h80, 1'b0, 32'h0);
        resolve(3'b000, 2'b00, 32'h200, 32'h200, 32'h204, 1'b0, 32'h0, 1'b1, 32'h200);
        idle(1);
        lookup("alias_old_tag", 32'h100, 1'b0, 32'h0);
        lookup("alias_new_tag", 32'h200, 1'b1, 32'h200);

        // BGE correctly predicted three times saturates at 11; one not-taken leaves 10
        for (int i = 0; i < 3; i++) begin
            resolve(3'b101, 2'b10, 32'h180, 32'h40, 32'h184, 1'b1, 32'h40, 1'b0, 32'h0);
        end
        lookup("bge_saturated", 32'h180, 1'b1, 32'h40);
        resolve(3'b101, 2'b01, 32'h180, 32'h40, 32'h184, 1'b1, 32'h40, 1'b1, 32'h184);
        idle(1);
        lookup("bge_after_nt", 32'h180, 1'b1, 32'h40);

        // funct3 010/011 are not branches: no redirect despite predicted-taken
        resolve(3'b010, 2'b00, 32'h1c0, 32'h999, 32'h1c4, 1'b1, 32'h999, 1'b0, 32'h0);
        resolve(3'b011, 2'b00, 32'h1c0, 32'h999, 32'h1c4, 1'b1, 32'h999, 1'b0, 32'h0);
        idle(1);
        lookup("nobranch_lookup", 32'h1c0, 1'b0, 32'h0);
        check("cnt16_final", {16'd0, mispredict_cnt}, 32'd5);
        check("cnt2_saturated", {30'd0, mispredict_cnt2}, 32'd3);

        // Reset during a pending redirect pulse
        ex_funct3 = 3'b000; ex_cmp = 2'b00; ex_pc = 32'h240; ex_target = 32'h44;
        ex_incpc = 32'h244; ex_pred_taken = 1'b0; ex_pred_target = 32'h0; ex_valid = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        check("pre_reset_pulse", {31'd0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
        check("rst_cnt2", {30'd0, mispredict_cnt2}, 32'd0);
        lookup("rst_lookup", 32'h100, 1'b0, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        check("scoreboard_drained", q_pc.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
